// File: rtl/first_nios2_system_cpu_div_cell.sv
// Radix-2 restoring 32-bit divider cell (DIVU/DIV/REMU/REM) for the Nios II multi-cycle ALU.
// Latency: done pulses in the 34th enabled cycle after start; clk_en low freezes all state.
module first_nios2_system_cpu_div_cell #(
  parameter logic [31:0] DIVZERO_QUOT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  input  logic [1:0]  n,
  output logic [31:0] result,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  logic        rsel_q, rsel_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;

  logic        a_neg, b_neg;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] quo, rmd;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    rsel_d   = rsel_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;

    a_neg   = n[0] & dataa[31];
    b_neg   = n[0] & datab[31];
    shifted = {rem_q, dvd_q[31]};
    ge      = (shifted >= {1'b0, dvs_q});
    quo     = qneg_q ? -dvd_q : dvd_q;
    if (dz_q) begin
      quo = DIVZERO_QUOT;
    end
    // A zero divisor lets every trial succeed, so rem ends as |dataa| and the sign fix restores dataa.
    rmd     = rneg_q ? -rem_q : rem_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = 6'd0;
          rsel_d  = n[1];
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = (datab == 32'd0);
          dvd_d   = a_neg ? -dataa : dataa;
          dvs_d   = b_neg ? -datab : datab;
          rem_d   = 32'd0;
        end
      end
      RUN: begin
        rem_d = ge ? 32'(shifted - {1'b0, dvs_q}) : shifted[31:0];
        dvd_d = {dvd_q[30:0], ge};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = rsel_q ? rmd : quo;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en) begin
      rsel_q <= rsel_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_first_nios2_system_cpu_div_cell.sv
// Directed and random bench for the divider cell with a cycle-level reference model.
module tb_first_nios2_system_cpu_div_cell;

  localparam logic [31:0] DZQ = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [1:0]  n;
  logic [31:0] result;
  logic        done;

  int n_checks = 0;
  int n_fails  = 0;
  bit chk_on   = 1'b0;

  first_nios2_system_cpu_div_cell #(.DIVZERO_QUOT(DZQ)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .datab  (datab),
    .n      (n),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : DZQ;
    if (op[0]) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'h0 : 32'h80000000;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  // Transaction-level model: an accepted start yields its result 34 enabled cycles later.
  logic        m_busy   = 1'b0;
  int          m_remain = 0;
  logic        m_done   = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_pend   = 32'd0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_result = 32'd0;
    end else if (clk_en) begin
      m_done = 1'b0;
      if (m_busy) begin
        m_remain--;
        if (m_remain == 0) begin
          m_busy   = 1'b0;
          m_done   = 1'b1;
          m_result = m_pend;
        end
      end else if (start) begin
        m_busy   = 1'b1;
        m_remain = 33;
        m_pend   = ref_res(dataa, datab, n);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_checks++;
      if (done !== m_done) begin
        n_fails++;
        $display("FAIL model_done t=%0t: got %b want %b", $time, done, m_done);
      end
      n_checks++;
      if (result !== m_result) begin
        n_fails++;
        $display("FAIL model_result t=%0t: got %h want %h", $time, result, m_result);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Called right after a falling edge; returns on the falling edge where done is seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] exp_res, input int exp_lat,
                        input int stall_at, input int inj_at, input string name);
    int lat;
    dataa = a;
    datab = b;
    n     = op;
    start = 1'b1;
    lat   = 0;
    do begin
      @(negedge clk);
      lat++;
      start = (lat == inj_at);
      if (lat == inj_at) begin
        dataa = ~a;
        datab = 32'd3;
        n     = ~op;
      end
      if (lat == stall_at) clk_en = 1'b0;
      if (lat == stall_at + 10) clk_en = 1'b1;
    end while (done !== 1'b1 && lat < 200);
    start  = 1'b0;
    clk_en = 1'b1;
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_result"}, result, exp_res);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;

    reset  = 1'b1;
    clk_en = 1'b0;
    start  = 1'b0;
    dataa  = 32'd0;
    datab  = 32'd0;
    n      = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_result", result, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset  = 1'b0;
    clk_en = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    run_op(32'd100, 32'd7, 2'd0, 32'd14, 34, -100, -1, "divu_100_7");
    @(negedge clk);
    run_op(32'd100, 32'd7, 2'd2, 32'd2, 34, -100, -1, "remu_100_7");
    run_op(32'hFFFFFFF9, 32'd2, 2'd1, 32'hFFFFFFFD, 34, -100, -1, "div_m7_2");
    run_op(32'hFFFFFFF9, 32'd2, 2'd3, 32'hFFFFFFFF, 34, -100, -1, "rem_m7_2");
    run_op(32'd7, 32'hFFFFFFFE, 2'd1, 32'hFFFFFFFD, 34, -100, -1, "div_7_m2");
    run_op(32'd7, 32'hFFFFFFFE, 2'd3, 32'd1, 34, -100, -1, "rem_7_m2");
    run_op(32'd1234, 32'd0, 2'd0, 32'hFFFFFFFF, 34, -100, -1, "divu_by0");
    run_op(32'd1234, 32'd0, 2'd2, 32'd1234, 34, -100, -1, "remu_by0");
    run_op(32'hFFFFFFFB, 32'd0, 2'd1, 32'hFFFFFFFF, 34, -100, -1, "div_by0");
    run_op(32'hFFFFFFFB, 32'd0, 2'd3, 32'hFFFFFFFB, 34, -100, -1, "rem_by0");
    run_op(32'h80000000, 32'hFFFFFFFF, 2'd1, 32'h80000000, 34, -100, -1, "div_ovf");
    run_op(32'h80000000, 32'hFFFFFFFF, 2'd3, 32'h0, 34, -100, -1, "rem_ovf");
    run_op(32'h80000000, 32'd2, 2'd1, 32'hC0000000, 34, -100, -1, "div_min_2");
    run_op(32'h80000000, 32'h80000000, 2'd0, 32'd1, 34, -100, -1, "divu_min_min");
    run_op(32'hFFFFFFFF, 32'h10, 2'd2, 32'hF, 34, -100, -1, "remu_max_16");

    @(negedge clk);
    run_op(32'd100, 32'd7, 2'd0, 32'd14, 44, 10, -1, "stall10");
    @(negedge clk);
    run_op(32'd1000, 32'd10, 2'd0, 32'd100, 34, -100, 5, "start_in_run");

    // Reset lands on the 16th step edge (iteration 15) and must abort silently.
    @(negedge clk);
    begin
      int lat;
      dataa = 32'd1000;
      datab = 32'd3;
      n     = 2'd0;
      start = 1'b1;
      lat   = 0;
      repeat (60) begin
        @(negedge clk);
        lat++;
        start = 1'b0;
        if (lat == 16) reset = 1'b1;
        if (lat == 17) reset = 1'b0;
        check("abort_no_done", {31'd0, done}, 32'd0);
      end
      check("abort_result", result, 32'd0);
    end
    run_op(32'hFFFFFFFF, 32'd1, 2'd0, 32'hFFFFFFFF, 34, -100, -1, "after_reset");

    @(negedge clk);
    run_op(32'd50, 32'd5, 2'd0, 32'd10, 34, -100, -1, "b2b_first");
    run_op(32'd51, 32'd5, 2'd2, 32'd1, 34, -100, -1, "b2b_second");

    for (int i = 0; i < 2000; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom;
        1: rb = $urandom_range(1, 255);
        2: rb = -$urandom_range(1, 255);
        default: rb = (i % 40 == 3) ? 32'd0 : $urandom_range(1, 65535);
      endcase
      if (i % 97 == 0) ra = 32'h80000000;
      rop = 2'($urandom_range(0, 3));
      run_op(ra, rb, rop, ref_res(ra, rb, rop), 34, -100, -1, "random");
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
